// File: rtl/spike_event_sender.sv
// rtl/spike_event_sender.sv - queues spiking neuron ids as packets, writes back potentials, closes each timestep with a marker packet
module spike_event_sender #(
    parameter int               NID_W      = 8,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [NID_W-1:0] EOT_ID     = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [7:0]         cluster_id,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NID_W-1:0]   in_neuron_id,
    input  logic               in_spike,
    input  logic [31:0]        in_potential,
    output logic               pot_wr_en,
    output logic [NID_W-1:0]   pot_wr_addr,
    output logic [31:0]        pot_wr_data,
    input  logic               ts_end,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic [8+NID_W-1:0] pkt_data,
    output logic               pkt_eot,
    output logic               ts_done,
    output logic [15:0]        spike_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, EOT, DONE} state_t;

    state_t           state_q;
    logic [NID_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             eot_pending_q;
    logic [15:0]      spike_count_q;
    logic             pot_wr_en_q;
    logic [NID_W-1:0] pot_wr_addr_q;
    logic [31:0]      pot_wr_data_q;

    logic fifo_empty, fifo_full, streaming, accept, push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign streaming  = (state_q == IDLE) || (state_q == SEND);
    assign in_ready   = !rst && !clear && !fifo_full && !eot_pending_q && streaming;
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_spike;
    assign pop        = streaming && !fifo_empty && pkt_ready;

    // Head of the queue is presented directly; the marker replaces it in EOT.
    assign pkt_valid  = streaming ? !fifo_empty : (state_q == EOT);
    assign pkt_eot    = (state_q == EOT);
    assign pkt_data   = !pkt_valid ? '0 : {cluster_id, (pkt_eot ? EOT_ID : mem_q[rd_ptr_q])};
    assign ts_done    = (state_q == DONE);

    assign spike_count = spike_count_q;
    assign pot_wr_en   = pot_wr_en_q;
    assign pot_wr_addr = pot_wr_addr_q;
    assign pot_wr_data = pot_wr_data_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_neuron_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            eot_pending_q <= 1'b0;
            spike_count_q <= '0;
            pot_wr_en_q   <= 1'b0;
            pot_wr_addr_q <= '0;
            pot_wr_data_q <= '0;
        end else if (clear) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            eot_pending_q <= 1'b0;
            spike_count_q <= '0;
            pot_wr_en_q   <= 1'b0;
        end else begin
            pot_wr_en_q <= accept;
            if (accept) begin
                pot_wr_addr_q <= in_neuron_id;
                pot_wr_data_q <= in_potential;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (spike_count_q != 16'hFFFF) begin
                    spike_count_q <= spike_count_q + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            case (state_q)
                IDLE, SEND: begin
                    if (ts_end && !eot_pending_q) begin
                        eot_pending_q <= 1'b1;
                    end
                    if (eot_pending_q && fifo_empty && !push) begin
                        state_q <= EOT;
                    end else if (!fifo_empty) begin
                        state_q <= SEND;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                EOT: begin
                    if (pkt_ready) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    eot_pending_q <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spike_event_sender.md
SPIKE_EVENT_SENDER -- requirements
Module: spike_event_sender

Interface
REQ-001 SHALL have parameter NID_W, default 8, neuron index width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, spike queue entries (power of 2, at least 2).
REQ-003 SHALL have parameter EOT_ID, default all-ones, neuron field of the end-of-timestep marker packet.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clear  in  1  timestep-start pulse; synchronous flush.
REQ-007 cluster_id  in  8  source cluster, placed in every packet.
REQ-008 in_valid  in  1  neuron result present.
REQ-009 in_ready  out  1  neuron result accepted when in_valid and in_ready are both high.
REQ-010 in_neuron_id  in  NID_W  neuron index of the result.
REQ-011 in_spike  in  1  neuron fired.
REQ-012 in_potential  in  32  IEEE-754 single final potential.
REQ-013 pot_wr_en  out  1  potential writeback strobe.
REQ-014 pot_wr_addr  out  NID_W  writeback address.
REQ-015 pot_wr_data  out  32  writeback value.
REQ-016 ts_end  in  1  pulse: no more neuron results this timestep.
REQ-017 pkt_valid  out  1  packet valid to the network interface.
REQ-018 pkt_ready  in  1  network interface accepts the packet.
REQ-019 pkt_data  out  8+NID_W  {cluster_id, neuron_id}.
REQ-020 pkt_eot  out  1  high on the end-of-timestep marker packet.
REQ-021 ts_done  out  1  one-cycle pulse after the marker packet is accepted.
REQ-022 spike_count  out  16  spikes accepted since the last clear.

Function
REQ-023 FSM states SHALL be IDLE, SEND, EOT and DONE, with IDLE as the reset state.
REQ-024 in_ready SHALL be high only when the FIFO is not full, eot_pending is 0, and the state is IDLE or SEND.
REQ-025 An accepted result SHALL produce pot_wr_en=1 one cycle later, with pot_wr_addr and pot_wr_data registered from the result, whether or not it spiked.
REQ-026 An accepted result with in_spike=1 SHALL push in_neuron_id into the FIFO and increment spike_count, saturating at 16'hFFFF.
REQ-027 A result with in_spike=0 SHALL NOT be queued.
REQ-028 The FIFO SHALL be first-word-fall-through; in IDLE/SEND, pkt_valid = FIFO not empty, pkt_data = {cluster_id, head}, and pkt_eot=0.
REQ-029 A pop SHALL occur on pkt_valid and pkt_ready both high; pkt_data SHALL stay stable while pkt_valid is high and pkt_ready is low.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged, and the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 The FSM SHALL move IDLE->SEND when the FIFO is non-empty, and SEND->IDLE when the FIFO is empty and eot_pending=0.
REQ-032 ts_end in IDLE/SEND SHALL set eot_pending; ts_end coincident with an accepted result SHALL accept that result first.
REQ-033 ts_end while eot_pending=1, or in EOT/DONE, SHALL be ignored.
REQ-034 With eot_pending=1 and the FIFO empty (and no push that cycle), the FSM SHALL go to EOT.
REQ-035 In EOT, outputs SHALL be pkt_valid=1, pkt_eot=1, pkt_data={cluster_id, EOT_ID}; on pkt_ready, the FSM SHALL go to DONE.
REQ-036 In DONE, the block SHALL set ts_done=1 for exactly one cycle, clear eot_pending, and return to IDLE.
REQ-037 clear SHALL, next cycle, flush the FIFO, zero spike_count, clear eot_pending, force IDLE, deassert pkt_valid and pot_wr_en, and accept no input during the clear cycle.
REQ-038 clear abandoning an in-flight packet SHALL be legal; rst SHALL have priority over clear.

Reset
REQ-039 On rst, outputs SHALL be: in_ready=0 during rst, pkt_valid=0, pkt_eot=0, pkt_data=0, pot_wr_en=0, pot_wr_addr=0, pot_wr_data=0, ts_done=0, spike_count=0.
REQ-040 On rst, the FIFO SHALL be empty, eot_pending=0, and the state IDLE.
REQ-041 in_ready SHALL rise the first cycle after rst deasserts.

Verification
REQ-042 Results for ids 3 (spike), 4 (no spike), 5 (spike) with pkt_ready=1 -> three writebacks; packets 0xA503 then 0xA505 (cluster_id=0xA5); spike_count=2.
REQ-043 Nine spikes with pkt_ready=0 -> in_ready low after 8 pushes; releasing pkt_ready -> all 9 packets in order; pkt_data stable while stalled.
REQ-044 ts_end with 2 spikes queued -> 2 spike packets, then the marker {0xA5,0xFF} with pkt_eot=1, then ts_done for 1 cycle; in_ready stays 0 until IDLE.
REQ-045 clear while pkt_valid=1 with 4 queued -> pkt_valid=0 the next cycle, spike_count=0, no marker and no ts_done.
REQ-046 Continuous push and pop at full throughput over 20 spikes -> no drops, order preserved, correct pointer wrap.
REQ-047 rst asserted in EOT -> IDLE, pkt_valid=0, and no ts_done pulse.
